// File: rtl/seg7_pkg.sv
// Shared types and glyph helpers for the seven-segment display controller.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ABS    = 2'd1,
    SHIFT  = 2'd2,
    FORMAT = 2'd3
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  // Active-low {dp,g,f,e,d,c,b,a} pattern for a hex nibble, dp off.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      default: seg = 8'h8E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_display_ctrl_if.sv
// Load channel of the seven-segment display controller.
// Handshake: a transfer happens on a rising edge where load_valid & load_ready;
// value_in/mode_hex/blank_lz/dp_mask matter only on that edge, and load_valid
// seen while load_ready is low is dropped, not queued.
interface seg7_display_ctrl_if #(
  parameter int NUM_DIGITS = 6,
  parameter int DATA_W     = 20
);
  logic [DATA_W-1:0]     value_in;
  logic                  mode_hex;
  logic                  blank_lz;
  logic [NUM_DIGITS-1:0] dp_mask;
  logic                  load_valid;
  logic                  load_ready;

  modport master (
    output value_in, mode_hex, blank_lz, dp_mask, load_valid,
    input  load_ready
  );

  modport slave (
    input  value_in, mode_hex, blank_lz, dp_mask, load_valid,
    output load_ready
  );
endinterface

// File: rtl/seg7_bcd_conv.sv
// Iterative double-dabble binary-to-BCD converter, one bit per cycle.
// last is high during the cycle whose edge completes the final iteration.
module seg7_bcd_conv #(
  parameter int DATA_W      = 20,
  parameter int CONV_DIGITS = 7
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic                       start,
  input  logic [DATA_W-1:0]          mag,
  output logic                       last,
  output logic [4*CONV_DIGITS-1:0]   bcd
);

  localparam int BW    = 4 * CONV_DIGITS;
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic              busy;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] sh;
  logic [BW-1:0]     adj;

  always_comb begin
    adj = bcd;
    for (int i = 0; i < CONV_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  assign last = busy && (cnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      busy <= 1'b0;
      cnt  <= '0;
      sh   <= '0;
      bcd  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      sh   <= mag;
      bcd  <= '0;
    end else if (busy) begin
      bcd <= {adj[BW-2:0], sh[DATA_W-1]};
      sh  <= {sh[DATA_W-2:0], 1'b0};
      cnt <= cnt + CNT_W'(1);
      if (last) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/seg7_display_ctrl.sv
// Seven-segment display controller: hex or signed-decimal rendering with
// blanking, sign, overflow dashes and decimal points. Optional SEG7_BLINK_EN.
module seg7_display_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int DATA_W     = 20
`ifdef SEG7_BLINK_EN
  , parameter int BLINK_DIV = 25_000_000
`endif
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  seg7_display_ctrl_if.slave      load,
`ifdef SEG7_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
  output logic                    update_done,
  output logic [8*NUM_DIGITS-1:0] seg_out,
  output state_t                  state_dbg
);

  localparam int CONV_DIGITS = (DATA_W * 3) / 10 + 1;
  // Nibble span wide enough for either the BCD result or the hex value.
  localparam int NW    = (CONV_DIGITS > NUM_DIGITS) ? CONV_DIGITS : NUM_DIGITS;
  localparam int SRC_W = 4 * NW;

  state_t state, state_next;

  logic [DATA_W-1:0]        value_q;
  logic                     mode_q;
  logic                     blank_q;
  logic [NUM_DIGITS-1:0]    dp_q;
  logic                     neg_q;
  logic [8*NUM_DIGITS-1:0]  seg_q;
  logic                     done_q;

  logic                     accept;
  logic [DATA_W-1:0]        mag;
  logic                     conv_last;
  logic [4*CONV_DIGITS-1:0] bcd;

  logic [SRC_W-1:0]         src;
  int                       msd;
  logic                     ovf;
  logic [7:0]               digit;
  logic [8*NUM_DIGITS-1:0]  seg_next;

  assign load.load_ready = (state == IDLE);
  assign accept          = load.load_valid && load.load_ready;
  assign state_dbg       = state;
  assign update_done     = done_q;

  always_ff @(posedge Clk) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load.load_valid) state_next = load.mode_hex ? FORMAT : ABS;
      ABS:     state_next = SHIFT;
      SHIFT:   if (conv_last) state_next = FORMAT;
      FORMAT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Unsigned magnitude: the most negative value maps to 2^(DATA_W-1) exactly.
  assign mag = value_q[DATA_W-1] ? (~value_q + DATA_W'(1)) : value_q;

  seg7_bcd_conv #(
    .DATA_W      (DATA_W),
    .CONV_DIGITS (CONV_DIGITS)
  ) u_conv (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .start   (state == ABS),
    .mag     (mag),
    .last    (conv_last),
    .bcd     (bcd)
  );

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      value_q <= '0;
      mode_q  <= 1'b0;
      blank_q <= 1'b0;
      dp_q    <= '0;
      neg_q   <= 1'b0;
      seg_q   <= '1;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state == FORMAT);
      if (accept) begin
        value_q <= load.value_in;
        mode_q  <= load.mode_hex;
        blank_q <= load.blank_lz;
        dp_q    <= load.dp_mask;
        neg_q   <= 1'b0;
      end
      if (state == ABS)    neg_q <= value_q[DATA_W-1];
      if (state == FORMAT) seg_q <= seg_next;
    end
  end

  // Hex and decimal share one path: a nonzero nibble that has no room on the
  // display (one fewer digit when the sign needs a place) is overflow.
  always_comb begin
    src = mode_q ? SRC_W'(value_q) : SRC_W'(bcd);
    msd = 0;
    for (int i = 0; i < NW; i++) begin
      if (src[4*i +: 4] != 4'd0) msd = i;
    end
    ovf      = neg_q ? (msd >= NUM_DIGITS - 1) : (msd >= NUM_DIGITS);
    seg_next = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digit = hex_to_seg(src[4*i +: 4]);
      if (ovf) begin
        digit = SEG_DASH;
      end else begin
        if (neg_q && (blank_q ? (i == msd + 1) : (i == NUM_DIGITS - 1)))
          digit = SEG_DASH;
        else if (blank_q && (i > msd))
          digit = SEG_BLANK;
        if (dp_q[i]) digit[7] = 1'b0;
      end
      seg_next[8*i +: 8] = digit;
    end
  end

`ifdef SEG7_BLINK_EN
  localparam int BCW = $clog2(BLINK_DIV + 1);

  logic [BCW-1:0] blink_cnt;
  logic           blink_phase;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BCW'(BLINK_DIV - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + BCW'(1);
    end
  end

  // Masking is on the output only, so seg_q survives the off phase.
  always_comb begin
    seg_out = seg_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (blink_phase && blink_mask[i]) seg_out[8*i +: 8] = SEG_BLANK;
    end
  end
`else
  assign seg_out = seg_q;
`endif

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Directed self-checking bench for seg7_display_ctrl at NUM_DIGITS=6, DATA_W=20.
module tb_seg7_display_ctrl;
  import seg7_pkg::*;

  localparam int ND = 6;
  localparam int DW = 20;
  localparam int DEC_LAT = DW + 2;

  logic            Clk = 1'b0;
  logic            Reset_n = 1'b0;
  logic            update_done;
  logic [8*ND-1:0] seg_out;
  state_t          state_dbg;
  int              total = 0;
  int              bad = 0;

  seg7_display_ctrl_if #(.NUM_DIGITS(ND), .DATA_W(DW)) load_if ();

`ifdef SEG7_BLINK_EN
  logic [ND-1:0] blink_mask = '0;
`endif

  seg7_display_ctrl #(
    .NUM_DIGITS (ND),
    .DATA_W     (DW)
`ifdef SEG7_BLINK_EN
    , .BLINK_DIV (4)
`endif
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .load        (load_if),
`ifdef SEG7_BLINK_EN
    .blink_mask  (blink_mask),
`endif
    .update_done (update_done),
    .seg_out     (seg_out),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // drivers (all called at #1 after a rising edge)
  task automatic start_load(input logic [DW-1:0] v, input logic hex, input logic blank,
                            input logic [ND-1:0] dp);
    int w;
    w = 0;
    load_if.value_in   = v;
    load_if.mode_hex   = hex;
    load_if.blank_lz   = blank;
    load_if.dp_mask    = dp;
    load_if.load_valid = 1'b1;
    while (!load_if.load_ready && w < 50) begin
      @(posedge Clk); #1;
      w++;
    end
    if (!load_if.load_ready) begin
      total++; bad++;
      $display("FAIL start_load: load_ready=0 after %0d cycles, required 1", w);
    end
    @(posedge Clk); #1;
    load_if.load_valid = 1'b0;
  endtask

  task automatic wait_update(input int limit, output int cycles, output bit ready_low);
    ready_low = 1'b1;
    for (cycles = 1; cycles <= limit; cycles++) begin
      @(posedge Clk); #1;
      if (update_done) return;
      if (load_if.load_ready) ready_low = 1'b0;
    end
  endtask

  // tests
  task automatic test_reset();
    Reset_n = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    total++; if (seg_out !== {ND{8'hFF}}) begin bad++; $display("FAIL reset_seg: got %h want %h", seg_out, {ND{8'hFF}}); end
    total++; if (load_if.load_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", load_if.load_ready); end
    total++; if (update_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", update_done); end
    total++; if (state_dbg !== IDLE) begin bad++; $display("FAIL reset_state: got %0d want %0d", state_dbg, IDLE); end
    Reset_n = 1'b1;
    @(posedge Clk); #1;
  endtask

  task automatic test_dec_neg();
    int cyc; bit rl;
    logic [8*ND-1:0] exp_seg;
    exp_seg = {8'hFF, 8'hFF, 8'hBF, 8'hF9, 8'hA4, 8'hB0};
    start_load(DW'(-123), 1'b0, 1'b1, '0);
    wait_update(40, cyc, rl);
    total++; if (cyc != DEC_LAT) begin bad++; $display("FAIL dec_latency: got %0d want %0d", cyc, DEC_LAT); end
    total++; if (!rl) begin bad++; $display("FAIL dec_busy_ready: load_ready rose early, want low while busy"); end
    total++; if (seg_out !== exp_seg) begin bad++; $display("FAIL dec_m123: got %h want %h", seg_out, exp_seg); end
    total++; if (load_if.load_ready !== 1'b1) begin bad++; $display("FAIL dec_ready_back: got %b want 1", load_if.load_ready); end
    @(posedge Clk); #1;
    total++; if (update_done !== 1'b0) begin bad++; $display("FAIL dec_done_pulse: got %b want 0", update_done); end
    total++; if (seg_out !== exp_seg) begin bad++; $display("FAIL dec_hold: got %h want %h", seg_out, exp_seg); end
  endtask

  task automatic test_dec_values();
    logic [DW-1:0]   tv  [6];
    logic            tb_ [6];
    logic [ND-1:0]   td  [6];
    logic [8*ND-1:0] te  [6];
    int cyc; bit rl;
    tv[0] = DW'(0);       tb_[0] = 1'b1; td[0] = 6'b000000; te[0] = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0};
    tv[1] = DW'(-99999);  tb_[1] = 1'b0; td[1] = 6'b000000; te[1] = {8'hBF, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90};
    tv[2] = DW'(-100000); tb_[2] = 1'b1; td[2] = 6'b111111; te[2] = {ND{8'hBF}};
    tv[3] = DW'(4096);    tb_[3] = 1'b0; td[3] = 6'b000000; te[3] = {8'hC0, 8'hC0, 8'h99, 8'hC0, 8'h90, 8'h82};
    tv[4] = DW'(-7);      tb_[4] = 1'b0; td[4] = 6'b100010; te[4] = {8'h3F, 8'hC0, 8'hC0, 8'hC0, 8'h40, 8'hF8};
    tv[5] = DW'(524287);  tb_[5] = 1'b1; td[5] = 6'b000000; te[5] = {8'h92, 8'hA4, 8'h99, 8'hA4, 8'h80, 8'hF8};
    for (int k = 0; k < 6; k++) begin
      start_load(tv[k], 1'b0, tb_[k], td[k]);
      wait_update(40, cyc, rl);
      total++; if (cyc != DEC_LAT || seg_out !== te[k]) begin
        bad++; $display("FAIL dec_vec%0d: got %h after %0d cycles, want %h after %0d", k, seg_out, cyc, te[k], DEC_LAT);
      end
    end
  endtask

  task automatic test_hex();
    int cyc; bit rl;
    logic [8*ND-1:0] exp_seg;
    exp_seg = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h88, 8'h12};
    start_load(20'h000A5, 1'b1, 1'b1, 6'b000001);
    total++; if (load_if.load_ready !== 1'b0) begin bad++; $display("FAIL hex_busy: load_ready got %b want 0", load_if.load_ready); end
    wait_update(10, cyc, rl);
    total++; if (cyc != 1) begin bad++; $display("FAIL hex_latency: got %0d want 1", cyc); end
    total++; if (seg_out !== exp_seg) begin bad++; $display("FAIL hex_a5: got %h want %h", seg_out, exp_seg); end
    total++; if (load_if.load_ready !== 1'b1) begin bad++; $display("FAIL hex_ready_back: got %b want 1", load_if.load_ready); end
  endtask

  task automatic test_back_to_back();
    int cyc; bit rl;
    logic [8*ND-1:0] exp1, exp2;
    exp1 = {8'hFF, 8'hFF, 8'hFF, 8'hF9, 8'hA4, 8'hB0};
    exp2 = {8'hFF, 8'hFF, 8'h83, 8'h86, 8'h86, 8'h8E};
    load_if.value_in = DW'(123); load_if.mode_hex = 1'b0; load_if.blank_lz = 1'b1;
    load_if.dp_mask = '0; load_if.load_valid = 1'b1;
    @(posedge Clk); #1;
    load_if.value_in = 20'h0BEEF; load_if.mode_hex = 1'b1;
    wait_update(40, cyc, rl);
    total++; if (cyc != DEC_LAT || seg_out !== exp1) begin
      bad++; $display("FAIL b2b_first: got %h after %0d, want %h after %0d", seg_out, cyc, exp1, DEC_LAT);
    end
    @(posedge Clk); #1;
    total++; if (load_if.load_ready !== 1'b0 || update_done !== 1'b0 || seg_out !== exp1) begin
      bad++; $display("FAIL b2b_accept: ready=%b done=%b seg=%h, want ready=0 done=0 seg=%h", load_if.load_ready, update_done, seg_out, exp1);
    end
    load_if.load_valid = 1'b0;
    @(posedge Clk); #1;
    total++; if (update_done !== 1'b1 || seg_out !== exp2) begin
      bad++; $display("FAIL b2b_second: done=%b seg=%h, want done=1 seg=%h", update_done, seg_out, exp2);
    end
  endtask

  task automatic test_reset_abort();
    int cyc; bit rl; bit saw;
    logic [8*ND-1:0] exp_seg;
    exp_seg = {8'hFF, 8'hFF, 8'hBF, 8'hF9, 8'hA4, 8'hB0};
    start_load(DW'(456), 1'b0, 1'b1, '0);
    repeat (11) @(posedge Clk);
    #1;
    Reset_n = 1'b0;
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    total++; if (seg_out !== {ND{8'hFF}}) begin bad++; $display("FAIL abort_seg: got %h want %h", seg_out, {ND{8'hFF}}); end
    total++; if (load_if.load_ready !== 1'b1 || update_done !== 1'b0) begin
      bad++; $display("FAIL abort_ctrl: ready=%b done=%b want ready=1 done=0", load_if.load_ready, update_done);
    end
    saw = 1'b0;
    repeat (30) begin
      @(posedge Clk); #1;
      if (update_done) saw = 1'b1;
    end
    total++; if (saw) begin bad++; $display("FAIL abort_no_done: update_done seen=1 want 0"); end
    start_load(DW'(-123), 1'b0, 1'b1, '0);
    wait_update(40, cyc, rl);
    total++; if (cyc != DEC_LAT || seg_out !== exp_seg) begin
      bad++; $display("FAIL abort_reload: got %h after %0d, want %h after %0d", seg_out, cyc, exp_seg, DEC_LAT);
    end
  endtask

`ifdef SEG7_BLINK_EN
  task automatic test_blink();
    int cyc; bit rl; bit ok_rest; bit ok_alt; int t;
    logic [7:0] d0 [20];
    logic [8*ND-9:0] rest_exp;
    rest_exp = {8'hFF, 8'hFF, 8'hFF, 8'hF9, 8'hA4};
    start_load(DW'(123), 1'b0, 1'b1, '0);
    wait_update(40, cyc, rl);
    blink_mask = 6'b000001;
    ok_rest = 1'b1;
    for (int j = 0; j < 20; j++) begin
      @(posedge Clk); #1;
      d0[j] = seg_out[7:0];
      if (seg_out[8*ND-1:8] !== rest_exp) ok_rest = 1'b0;
    end
    t = -1;
    for (int j = 1; j < 20; j++) if (t < 0 && d0[j] !== d0[j-1]) t = j;
    ok_alt = (t > 0 && t <= 4);
    for (int j = (t > 0 ? t : 0); j < 20; j++) begin
      if (((j - t) / 4) % 2 == 0) begin
        if (d0[j] !== d0[t]) ok_alt = 1'b0;
      end else begin
        if (d0[j] !== (d0[t] == 8'hB0 ? 8'hFF : 8'hB0)) ok_alt = 1'b0;
      end
      if (d0[j] !== 8'hB0 && d0[j] !== 8'hFF) ok_alt = 1'b0;
    end
    total++; if (!ok_rest) begin bad++; $display("FAIL blink_steady: upper digits moved, want %h", rest_exp); end
    total++; if (!ok_alt) begin bad++; $display("FAIL blink_digit0: first toggle at %0d, want B0/FF alternating every 4", t); end
    blink_mask = '0;
  endtask
`endif

  initial begin
    load_if.value_in   = '0;
    load_if.mode_hex   = 1'b0;
    load_if.blank_lz   = 1'b0;
    load_if.dp_mask    = '0;
    load_if.load_valid = 1'b0;
    test_reset();
    test_dec_neg();
    test_dec_values();
    test_hex();
    test_back_to_back();
    test_reset_abort();
`ifdef SEG7_BLINK_EN
    test_blink();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
